food_spawner: RTL

- Parametrised successor to the single-apple generator for the grid snake game.
- Detects when the snake head reaches the current food cell on a slow game tick, then pulses a grow request.
- Draws a new food position from a free-running 16-bit LFSR, rejecting out-of-grid, head-coincident and body-occupied cells via an occupancy query handshake.
- Falls back to a deterministic raster scan when random draws keep failing. Sits between the snake body tracker (occupancy source) and the VGA renderer.

---
 rtl/food_spawner.sv | 254 +++++++++++++++++++++++++
 1 files changed

// File: rtl/food_spawner.sv
// rtl/food_spawner.sv - food cell generator with LFSR draw, occupancy query and raster-scan fallback (optional SPAWN_STATS_EN)
`timescale 1ns/1ps

module food_spawner #(
   parameter int          X_W       = 6,
   parameter int          Y_W       = 5,
   parameter int          GRID_W    = 35,
   parameter int          GRID_H    = 25,
   parameter int          TICK_DIV  = 250000,
   parameter int          MAX_TRIES = 15,
   parameter logic [15:0] LFSR_SEED = 16'hACE1,
   parameter int          INIT_X    = 24,
   parameter int          INIT_Y    = 10
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [X_W-1:0] head_x,
   input  logic [Y_W-1:0] head_y,
   output logic [X_W-1:0] occ_query_x,
   output logic [Y_W-1:0] occ_query_y,
   output logic           occ_query_vld,
   input  logic           occ_hit,
   output logic [X_W-1:0] apple_x,
   output logic [Y_W-1:0] apple_y,
   output logic           apple_valid,
   output logic           add_cube,
`ifdef SPAWN_STATS_EN
   output logic [15:0]    eaten_cnt,
`endif
   output logic           spawn_fail
);

   localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int TRW = (MAX_TRIES > 0) ? $clog2(MAX_TRIES + 1) : 1;

   localparam logic [X_W:0]   GW_LIM  = (X_W+1)'(GRID_W);
   localparam logic [Y_W:0]   GH_LIM  = (Y_W+1)'(GRID_H);
   localparam logic [X_W-1:0] LAST_X  = X_W'(GRID_W - 1);
   localparam logic [Y_W-1:0] LAST_Y  = Y_W'(GRID_H - 1);
   localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [TRW-1:0] TRY_LIM = TRW'(MAX_TRIES);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_DRAW = 3'd1;
   localparam logic [2:0] S_QRY  = 3'd2;
   localparam logic [2:0] S_WAIT = 3'd3;
   localparam logic [2:0] S_SCAN = 3'd4;

   logic [2:0]     state_q, state_d;
   logic [TW-1:0]  tick_cnt_q, tick_cnt_d;
   logic [15:0]    lfsr_q, lfsr_d;
   logic [TRW-1:0] tries_q, tries_d, tries_inc;
   logic           scan_mode_q, scan_mode_d;
   logic [X_W-1:0] scan_x_q, scan_x_d;
   logic [Y_W-1:0] scan_y_q, scan_y_d;
   logic [X_W-1:0] qx_q, qx_d;
   logic [Y_W-1:0] qy_q, qy_d;
   logic           qvld_q, qvld_d;
   logic [X_W-1:0] apple_x_q, apple_x_d;
   logic [Y_W-1:0] apple_y_q, apple_y_d;
   logic           apple_valid_q, apple_valid_d;
   logic           add_cube_q, add_cube_d;
   logic           spawn_fail_q, spawn_fail_d;

   logic           tick;
   logic [X_W-1:0] cand_x;
   logic [Y_W-1:0] cand_y;
   logic           cand_bad;
   logic           scan_last;
   logic           scan_on_head;

   assign tick         = (tick_cnt_q == TICK_LAST);
   assign cand_x       = lfsr_q[X_W-1:0];
   assign cand_y       = lfsr_q[X_W+Y_W-1:X_W];
   assign cand_bad     = ({1'b0, cand_x} >= GW_LIM) || ({1'b0, cand_y} >= GH_LIM) ||
                         ((cand_x == head_x) && (cand_y == head_y));
   assign tries_inc    = tries_q + TRW'(1);
   assign scan_last    = (scan_x_q == LAST_X) && (scan_y_q == LAST_Y);
   assign scan_on_head = (scan_x_q == head_x) && (scan_y_q == head_y);

   // Next-state logic: tick divider, LFSR and the eat/draw/query/scan sequencer
   always_comb begin
      state_d       = state_q;
      tick_cnt_d    = tick ? '0 : tick_cnt_q + TW'(1);
      lfsr_d        = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
      tries_d       = tries_q;
      scan_mode_d   = scan_mode_q;
      scan_x_d      = scan_x_q;
      scan_y_d      = scan_y_q;
      qx_d          = qx_q;
      qy_d          = qy_q;
      qvld_d        = 1'b0;
      apple_x_d     = apple_x_q;
      apple_y_d     = apple_y_q;
      apple_valid_d = apple_valid_q;
      add_cube_d    = 1'b0;
      spawn_fail_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (tick && apple_valid_q && (head_x == apple_x_q) && (head_y == apple_y_q)) begin
               add_cube_d    = 1'b1;
               apple_valid_d = 1'b0;
               tries_d       = '0;
               scan_mode_d   = 1'b0;
               state_d       = S_DRAW;
            end
         end
         S_DRAW: begin
            if (tries_q >= TRY_LIM) begin
               scan_mode_d = 1'b1;
               scan_x_d    = '0;
               scan_y_d    = '0;
               state_d     = S_SCAN;
            end else if (cand_bad) begin
               tries_d = tries_inc;
               if (tries_inc >= TRY_LIM) begin
                  scan_mode_d = 1'b1;
                  scan_x_d    = '0;
                  scan_y_d    = '0;
                  state_d     = S_SCAN;
               end
            end else begin
               qx_d    = cand_x;
               qy_d    = cand_y;
               qvld_d  = 1'b1;
               state_d = S_QRY;
            end
         end
         // The query strobe is on the wires this cycle; the answer arrives next cycle.
         S_QRY: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (!occ_hit) begin
               apple_x_d     = qx_q;
               apple_y_d     = qy_q;
               apple_valid_d = 1'b1;
               state_d       = S_IDLE;
            end else if (scan_mode_q) begin
               if (scan_last) begin
                  spawn_fail_d = 1'b1;
                  state_d      = S_IDLE;
               end else begin
                  scan_x_d = (scan_x_q == LAST_X) ? '0 : scan_x_q + X_W'(1);
                  scan_y_d = (scan_x_q == LAST_X) ? scan_y_q + Y_W'(1) : scan_y_q;
                  state_d  = S_SCAN;
               end
            end else begin
               tries_d = tries_inc;
               if (tries_inc >= TRY_LIM) begin
                  scan_mode_d = 1'b1;
                  scan_x_d    = '0;
                  scan_y_d    = '0;
                  state_d     = S_SCAN;
               end else begin
                  state_d = S_DRAW;
               end
            end
         end
         S_SCAN: begin
            if (scan_on_head) begin
               if (scan_last) begin
                  spawn_fail_d = 1'b1;
                  state_d      = S_IDLE;
               end else begin
                  scan_x_d = (scan_x_q == LAST_X) ? '0 : scan_x_q + X_W'(1);
                  scan_y_d = (scan_x_q == LAST_X) ? scan_y_q + Y_W'(1) : scan_y_q;
               end
            end else begin
               qx_d    = scan_x_q;
               qy_d    = scan_y_q;
               qvld_d  = 1'b1;
               state_d = S_QRY;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State registers; reset aborts any spawn in progress and restores the initial apple
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q       <= S_IDLE;
         tick_cnt_q    <= '0;
         lfsr_q        <= LFSR_SEED;
         tries_q       <= '0;
         scan_mode_q   <= 1'b0;
         scan_x_q      <= '0;
         scan_y_q      <= '0;
         qx_q          <= '0;
         qy_q          <= '0;
         qvld_q        <= 1'b0;
         apple_x_q     <= X_W'(INIT_X);
         apple_y_q     <= Y_W'(INIT_Y);
         apple_valid_q <= 1'b1;
         add_cube_q    <= 1'b0;
         spawn_fail_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         tick_cnt_q    <= tick_cnt_d;
         lfsr_q        <= lfsr_d;
         tries_q       <= tries_d;
         scan_mode_q   <= scan_mode_d;
         scan_x_q      <= scan_x_d;
         scan_y_q      <= scan_y_d;
         qx_q          <= qx_d;
         qy_q          <= qy_d;
         qvld_q        <= qvld_d;
         apple_x_q     <= apple_x_d;
         apple_y_q     <= apple_y_d;
         apple_valid_q <= apple_valid_d;
         add_cube_q    <= add_cube_d;
         spawn_fail_q  <= spawn_fail_d;
      end
   end

`ifdef SPAWN_STATS_EN
   logic [15:0] eaten_cnt_q;
   logic        scan_spawn_q;
   logic        scan_accept;

   assign scan_accept = (state_q == S_WAIT) && !occ_hit && scan_mode_q;

   // Saturating eat counter plus a sticky marker for apples placed by the raster scan
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         eaten_cnt_q  <= '0;
         scan_spawn_q <= 1'b0;
      end else begin
         if (add_cube_d && (eaten_cnt_q != 16'hFFFF)) begin
            eaten_cnt_q <= eaten_cnt_q + 16'd1;
         end
         if (scan_accept) begin
            scan_spawn_q <= 1'b1;
         end
      end
   end

   assign eaten_cnt = eaten_cnt_q;
`endif

   assign occ_query_x   = qx_q;
   assign occ_query_y   = qy_q;
   assign occ_query_vld = qvld_q;
   assign apple_x       = apple_x_q;
   assign apple_y       = apple_y_q;
   assign apple_valid   = apple_valid_q;
   assign add_cube      = add_cube_q;
   assign spawn_fail    = spawn_fail_q;

endmodule
